// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and types for the HuC6280 interrupt
//               controller: MMIO register offsets, vector select codes,
//               mask bit positions and the request FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Register offsets inside the interrupt MMIO window
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Vector select codes presented to the CPU sequencer
  localparam logic [1:0] VEC_NONE = 2'b00;
  localparam logic [1:0] VEC_TIQ  = 2'b01;
  localparam logic [1:0] VEC_IRQ1 = 2'b10;
  localparam logic [1:0] VEC_IRQ2 = 2'b11;

  // Bit positions shared by the mask register and the pending/enabled vectors
  localparam int MASK_IRQ2_BIT = 0;
  localparam int MASK_IRQ1_BIT = 1;
  localparam int MASK_TIQ_BIT  = 2;

  // Request handshake state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOCK = 2'd2
  } irq_state_e;

  // Fixed priority TIQ > IRQ1 > IRQ2 over the enabled source vector
  function automatic logic [1:0] irq_encode(input logic [2:0] enabled);
    if (enabled[MASK_TIQ_BIT])       return VEC_TIQ;
    else if (enabled[MASK_IRQ1_BIT]) return VEC_IRQ1;
    else if (enabled[MASK_IRQ2_BIT]) return VEC_IRQ2;
    else                             return VEC_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : SYNC_STAGES-deep flop chain bringing an asynchronous
//               active-low level into the core clock domain. The chain only
//               advances when en is high and resets to 1 (deasserted).
// Ports       : clk      - core clock
//               reset_n  - asynchronous active-low reset (chain -> all ones)
//               en       - advance enable (core clock enable)
//               d_i      - asynchronous input level
//               q_o      - synchronised output level
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else if (en) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : HuC6280 interrupt controller. Synchronises IRQ1/IRQ2,
//               holds the mask register (offset 2) and status/ack register
//               (offset 3), prioritises TIQ > IRQ1 > IRQ2 and runs the
//               request/lock handshake with the CPU sequencer.
// Ports       : clk, reset_n      - core clock, async active-low reset
//               clk_en            - core clock enable, gates all state
//               re, we, CEI_n     - MMIO read/write strobes, window select
//               addr, dIn, dOut   - register offset, write and read data
//               TIQ_n, TIQ_ack    - timer request level and acknowledge
//               IRQ1_n, IRQ2_n    - asynchronous external requests
//               int_n, vec_sel    - request and selected source to the CPU
//               int_ack, vec_done - CPU vector fetch start / end
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       re,
  input  logic       we,
  input  logic       CEI_n,
  input  logic [1:0] addr,
  input  logic [7:0] dIn,
  output logic [7:0] dOut,
  input  logic       TIQ_n,
  output logic       TIQ_ack,
  input  logic       IRQ1_n,
  input  logic       IRQ2_n,
  output logic       int_n,
  output logic [1:0] vec_sel,
  input  logic       int_ack,
  input  logic       vec_done
);

  // --------------------------------------------------------------------------
  // External line synchronisers
  // --------------------------------------------------------------------------
  logic irq1_sync;
  logic irq2_sync;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq1 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clk_en),
    .d_i     (IRQ1_n),
    .q_o     (irq1_sync)
  );

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq2 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clk_en),
    .d_i     (IRQ2_n),
    .q_o     (irq2_sync)
  );

  // --------------------------------------------------------------------------
  // Pending / enabled sources
  // --------------------------------------------------------------------------
  logic [2:0] pending;
  logic [2:0] enabled;
  logic [1:0] vec_enc;
  logic [2:0] mask_q;

  assign pending[MASK_TIQ_BIT]  = ~TIQ_n;
  assign pending[MASK_IRQ1_BIT] = ~irq1_sync;
  assign pending[MASK_IRQ2_BIT] = ~irq2_sync;

  assign enabled = pending & ~mask_q;
  assign vec_enc = irq_encode(enabled);

  // --------------------------------------------------------------------------
  // MMIO register writes
  // --------------------------------------------------------------------------
  logic sel_wr;
  logic mask_wr;
  logic status_wr;
  logic ack_pend_q;
  logic ack_pend_d;

  assign sel_wr    = ~CEI_n & we & clk_en;
  assign mask_wr   = sel_wr & (addr == ADDR_MASK);
  assign status_wr = sel_wr & (addr == ADDR_STATUS);

  // ack_pend lives for one clk_en period; a write in that period re-arms it
  assign ack_pend_d = status_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= 3'b000;
      ack_pend_q <= 1'b0;
    end else if (clk_en) begin
      ack_pend_q <= ack_pend_d;
      if (mask_wr) begin
        mask_q <= dIn[2:0];
      end
    end
  end

  assign TIQ_ack = ack_pend_q;

  // Only the low three data bits carry state
  logic unused_din;
  assign unused_din = ^dIn[7:3];

  // --------------------------------------------------------------------------
  // MMIO reads (combinational); status is raw, unmasked pending
  // --------------------------------------------------------------------------
  always_comb begin
    dOut = 8'h00;
    if (~CEI_n & re) begin
      case (addr)
        ADDR_MASK:   dOut = {5'b0, mask_q};
        ADDR_STATUS: dOut = {5'b0, pending};
        default:     dOut = 8'h00;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM; int_n and vec_sel are registered alongside the state
  // --------------------------------------------------------------------------
  irq_state_e state_q;
  irq_state_e state_d;
  logic       int_n_q;
  logic       int_n_d;
  logic [1:0] vec_sel_q;
  logic [1:0] vec_sel_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      int_n_q   <= 1'b1;
      vec_sel_q <= VEC_NONE;
    end else if (clk_en) begin
      state_q   <= state_d;
      int_n_q   <= int_n_d;
      vec_sel_q <= vec_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    int_n_d   = int_n_q;
    vec_sel_d = vec_sel_q;
    case (state_q)
      ST_IDLE: begin
        int_n_d   = 1'b1;
        vec_sel_d = VEC_NONE;
        if (enabled != 3'b000) begin
          state_d   = ST_REQ;
          int_n_d   = 1'b0;
          vec_sel_d = vec_enc;
        end
      end
      ST_REQ: begin
        // int_ack wins over a simultaneous withdrawal so the CPU's fetch
        // always gets the vector it already committed to
        if (int_ack) begin
          state_d = ST_LOCK;
          int_n_d = 1'b1;
        end else if (enabled == 3'b000) begin
          state_d   = ST_IDLE;
          int_n_d   = 1'b1;
          vec_sel_d = VEC_NONE;
        end else begin
          int_n_d   = 1'b0;
          vec_sel_d = vec_enc;
        end
      end
      ST_LOCK: begin
        int_n_d = 1'b1;
        if (vec_done) begin
          state_d   = ST_IDLE;
          vec_sel_d = VEC_NONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        int_n_d   = 1'b1;
        vec_sel_d = VEC_NONE;
      end
    endcase
  end

  assign int_n   = int_n_q;
  assign vec_sel = vec_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_en;
  logic       re;
  logic       we;
  logic       CEI_n;
  logic [1:0] addr;
  logic [7:0] dIn;
  logic [7:0] dOut;
  logic       TIQ_n;
  logic       TIQ_ack;
  logic       IRQ1_n;
  logic       IRQ2_n;
  logic       int_n;
  logic [1:0] vec_sel;
  logic       int_ack;
  logic       vec_done;

  int errors = 0;
  int checks = 0;

  irq_controller #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .re       (re),
    .we       (we),
    .CEI_n    (CEI_n),
    .addr     (addr),
    .dIn      (dIn),
    .dOut     (dOut),
    .TIQ_n    (TIQ_n),
    .TIQ_ack  (TIQ_ack),
    .IRQ1_n   (IRQ1_n),
    .IRQ2_n   (IRQ2_n),
    .int_n    (int_n),
    .vec_sel  (vec_sel),
    .int_ack  (int_ack),
    .vec_done (vec_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs are then changed/sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [7:0] exp);
    CEI_n = 1'b0; re = 1'b1; addr = a;
    #1;
    check(tag, dOut, exp);
    CEI_n = 1'b1; re = 1'b0;
  endtask

  // Write presented for exactly one clock edge
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    CEI_n = 1'b0; we = 1'b1; addr = a; dIn = d;
    tick();
    CEI_n = 1'b1; we = 1'b0; dIn = 8'h00;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [1:0] vs);
    check({tag, ".int_n"}, {7'b0, int_n}, {7'b0, en});
    check({tag, ".vec_sel"}, {6'b0, vec_sel}, {6'b0, vs});
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; re = 1'b0; we = 1'b0; CEI_n = 1'b1;
    addr = 2'd0; dIn = 8'h00; TIQ_n = 1'b1; IRQ1_n = 1'b1; IRQ2_n = 1'b1;
    int_ack = 1'b0; vec_done = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state and idle reads
    chk_out("reset", 1'b1, 2'b00);
    check("reset.TIQ_ack", {7'b0, TIQ_ack}, 8'h00);
    rd(2'd2, "rd_mask_reset", 8'h00);
    rd(2'd3, "rd_status_reset", 8'h00);
    rd(2'd0, "rd_addr0", 8'h00);
    addr = 2'd2; CEI_n = 1'b0; re = 1'b0; #1;
    check("rd_no_strobe", dOut, 8'h00);
    CEI_n = 1'b1;

    // Timer request and acknowledge pulse
    TIQ_n = 1'b0;
    tick();
    chk_out("tiq_req", 1'b0, 2'b01);
    rd(2'd3, "rd_status_tiq", 8'h04);
    wr(2'd3, 8'hFF);
    check("tiq_ack_on", {7'b0, TIQ_ack}, 8'h01);
    tick();
    check("tiq_ack_off", {7'b0, TIQ_ack}, 8'h00);
    TIQ_n = 1'b1;
    tick();
    chk_out("tiq_withdrawn", 1'b1, 2'b00);

    // Back-to-back status writes keep the ack armed
    CEI_n = 1'b0; we = 1'b1; addr = 2'd3;
    tick();
    check("rearm_1", {7'b0, TIQ_ack}, 8'h01);
    tick();
    check("rearm_2", {7'b0, TIQ_ack}, 8'h01);
    CEI_n = 1'b1; we = 1'b0;
    tick();
    check("rearm_off", {7'b0, TIQ_ack}, 8'h00);

    // External lines through the synchroniser, then masking
    IRQ1_n = 1'b0; IRQ2_n = 1'b0;
    tick();
    rd(2'd3, "sync_stage1", 8'h00);
    tick();
    chk_out("sync_latency", 1'b1, 2'b00);
    rd(2'd3, "rd_status_irq", 8'h03);
    tick();
    chk_out("irq1_req", 1'b0, 2'b10);
    wr(2'd2, 8'h02);
    chk_out("mask_lag", 1'b0, 2'b10);
    tick();
    chk_out("irq2_req", 1'b0, 2'b11);
    rd(2'd2, "rd_mask_02", 8'h02);
    wr(2'd2, 8'h03);
    tick();
    chk_out("all_masked", 1'b1, 2'b00);
    rd(2'd3, "rd_status_masked", 8'h03);

    // Handshake: REQ -> LOCK -> IDLE -> REQ
    wr(2'd2, 8'h00);
    tick();
    chk_out("unmask_req", 1'b0, 2'b10);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk_out("lock", 1'b1, 2'b10);
    TIQ_n = 1'b0;
    tick();
    tick();
    chk_out("lock_frozen", 1'b1, 2'b10);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk_out("lock_ack_ignored", 1'b1, 2'b10);
    vec_done = 1'b1;
    tick();
    vec_done = 1'b0;
    chk_out("vec_done_idle", 1'b1, 2'b00);
    tick();
    chk_out("rereq_tiq", 1'b0, 2'b01);

    // int_ack beats a simultaneous withdrawal
    wr(2'd2, 8'h07);
    chk_out("pre_race", 1'b0, 2'b01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk_out("ack_priority", 1'b1, 2'b01);
    wr(2'd2, 8'h00);

    // Asynchronous reset while locked, clock enable low
    clk_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 1'b1, 2'b00);
    check("async_reset.TIQ_ack", {7'b0, TIQ_ack}, 8'h00);
    rd(2'd2, "rd_mask_async", 8'h00);
    rd(2'd3, "rd_status_async", 8'h04);
    tick();
    reset_n = 1'b1;
    tick();

    // Clock enable low blocks every update
    wr(2'd2, 8'h07);
    rd(2'd2, "rd_mask_gated", 8'h00);
    wr(2'd3, 8'hFF);
    check("gated_ack", {7'b0, TIQ_ack}, 8'h00);
    tick();
    check("gated_ack2", {7'b0, TIQ_ack}, 8'h00);
    chk_out("gated_fsm", 1'b1, 2'b00);
    rd(2'd3, "rd_status_gated_sync", 8'h04);
    clk_en = 1'b1;
    wr(2'd2, 8'h05);
    rd(2'd2, "rd_mask_05", 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
